register_file_2r1w: RTL and testbench



---
 rtl/register_file_2r1w_pkg.sv | 22 ++
 rtl/register_file_2r1w_if.sv | 33 +++
 rtl/register_file_2r1w_word.sv | 32 +++
 rtl/register_file_2r1w.sv | 54 +++++
 tb/tb_register_file_2r1w.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/register_file_2r1w_pkg.sv
// +-------------------------------------------------------------------------+
// | register_file_2r1w_pkg : shared widths and named register indices  rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

package register_file_2r1w_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [REG_ADDR_W-1:0] {
    ZERO = 5'd0,
    SP   = 5'd29,
    RA   = 5'd31
  } reg_idx_e;

endpackage

`default_nettype wire

// File: rtl/register_file_2r1w_if.sv
// +-------------------------------------------------------------------------+
// | register_file_2r1w_if : two read ports and one write port      rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

interface register_file_2r1w_if
  import register_file_2r1w_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [WIDTH-1:0]  read_data1;
  logic [WIDTH-1:0]  read_data2;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic              write_en;

  modport master (
    output read_addr1, read_addr2, write_addr, write_data, write_en,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_addr1, read_addr2, write_addr, write_data, write_en,
    output read_data1, read_data2
  );

endinterface

`default_nettype wire

// File: rtl/register_file_2r1w_word.sv
// +-------------------------------------------------------------------------+
// | register_word : WIDTH-bit enabled D register, async active-low clear rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module register_word
  import register_file_2r1w_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/register_file_2r1w.sv
// +-------------------------------------------------------------------------+
// | register_file_2r1w : 2-read/1-write register file, r0 hardwired   rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module register_file_2r1w
  import register_file_2r1w_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  register_file_2r1w_if.slave  bus
);

  localparam bit c_bypass = (BYPASS != 0);

  logic [WIDTH-1:0] w_q [DEPTH];
  logic             w_wr_ok;
  logic             w_hit1;
  logic             w_hit2;

  // Register 0 has no storage; its slot in the read array is a constant.
  assign w_q[0] = '0;

  assign w_wr_ok = rst_n && bus.write_en && (bus.write_addr != ADDR_W'(ZERO_REG));

  generate
    for (genvar i = 1; i < DEPTH; i++) begin : g_regs
      register_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_wr_ok && (bus.write_addr == ADDR_W'(i))),
        .i_d   (bus.write_data),
        .o_q   (w_q[i])
      );
    end
  endgenerate

  // Forwarding reuses w_wr_ok, so r0 writes and writes under reset never bypass.
  assign w_hit1 = c_bypass && w_wr_ok && (bus.write_addr == bus.read_addr1);
  assign w_hit2 = c_bypass && w_wr_ok && (bus.write_addr == bus.read_addr2);

  assign bus.read_data1 = !rst_n ? '0 : (w_hit1 ? bus.write_data : w_q[bus.read_addr1]);
  assign bus.read_data2 = !rst_n ? '0 : (w_hit2 ? bus.write_data : w_q[bus.read_addr2]);

endmodule

`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
// +-------------------------------------------------------------------------+
// | tb_register_file_2r1w : scoreboard bench, BYPASS=1 and BYPASS=0 side by side rev 1.0 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_register_file_2r1w;

  logic clk;
  logic rst_n;

  register_file_2r1w_if #(.WIDTH(32), .ADDR_W(5)) bus_b ();
  register_file_2r1w_if #(.WIDTH(32), .ADDR_W(5)) bus_n ();

  register_file_2r1w #(.BYPASS(1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  register_file_2r1w #(.BYPASS(0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  assign bus_n.read_addr1 = bus_b.read_addr1;
  assign bus_n.read_addr2 = bus_b.read_addr2;
  assign bus_n.write_addr = bus_b.write_addr;
  assign bus_n.write_data = bus_b.write_data;
  assign bus_n.write_en   = bus_b.write_en;

  // Observed word: {bypass rd1, bypass rd2, no-bypass rd1, no-bypass rd2}
  logic [127:0] w_obs;
  assign w_obs = {bus_b.read_data1, bus_b.read_data2, bus_n.read_data1, bus_n.read_data2};

  logic [127:0] sb[$];
  logic [127:0] exp_v;
  int n_vec  = 0;
  int n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_b.write_en   = 1'b1;
    bus_b.write_addr = a;
    bus_b.write_data = d;
    @(posedge clk);
    #1;
    bus_b.write_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_b.write_en = 1'b1; bus_b.write_addr = 5'd5; bus_b.write_data = 32'hFFFF_FFFF;
    bus_b.read_addr1 = 5'd5; bus_b.read_addr2 = 5'd5;
    sb.push_back('0);
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL reset_rd got %h want %h", w_obs, exp_v); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus_b.write_en = 1'b0;
    sb.push_back('0);
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL write_in_reset got %h want %h", w_obs, exp_v); end
    wr(5'd5, 32'hDEAD_BEEF);
    sb.push_back({4{32'hDEAD_BEEF}});
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL r5_written got %h want %h", w_obs, exp_v); end
    rst_n = 1'b0;
    sb.push_back('0);
    #1; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL async_clear got %h want %h", w_obs, exp_v); end
    rst_n = 1'b1;
    sb.push_back('0);
    #1; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL clear_held got %h want %h", w_obs, exp_v); end
  endtask

  task automatic test_basic;
    wr(5'd7, 32'h1234_5678);
    bus_b.read_addr1 = 5'd7; bus_b.read_addr2 = 5'd7;
    sb.push_back({4{32'h1234_5678}});
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL basic_r7 got %h want %h", w_obs, exp_v); end
    bus_b.read_addr1 = 5'd6; bus_b.read_addr2 = 5'd8;
    sb.push_back('0);
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL basic_neighbours got %h want %h", w_obs, exp_v); end
  endtask

  task automatic test_zero;
    bus_b.write_en = 1'b1; bus_b.write_addr = 5'd0; bus_b.write_data = 32'hFFFF_FFFF;
    bus_b.read_addr1 = 5'd0; bus_b.read_addr2 = 5'd0;
    sb.push_back('0);
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL zero_pre got %h want %h", w_obs, exp_v); end
    @(posedge clk); #1;
    bus_b.write_en = 1'b0;
    sb.push_back('0);
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL zero_post got %h want %h", w_obs, exp_v); end
  endtask

  task automatic test_bypass;
    wr(5'd3, 32'h0000_0011);
    bus_b.write_en = 1'b1; bus_b.write_addr = 5'd3; bus_b.write_data = 32'h0000_0022;
    bus_b.read_addr1 = 5'd3; bus_b.read_addr2 = 5'd3;
    sb.push_back({32'h22, 32'h22, 32'h11, 32'h11});
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL bypass_pre got %h want %h", w_obs, exp_v); end
    @(posedge clk); #1;
    bus_b.write_en = 1'b0;
    sb.push_back({4{32'h0000_0022}});
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL bypass_post got %h want %h", w_obs, exp_v); end
    bus_b.write_en = 1'b1; bus_b.write_data = 32'h0000_0033;
    bus_b.read_addr1 = 5'd4; bus_b.read_addr2 = 5'd3;
    sb.push_back({32'h0, 32'h33, 32'h0, 32'h22});
    #2; exp_v = sb.pop_front(); n_vec++;
    if (w_obs !== exp_v) begin n_miss++; $display("FAIL bypass_one_port got %h want %h", w_obs, exp_v); end
    @(posedge clk); #1;
    bus_b.write_en = 1'b0;
  endtask

  task automatic test_write_disable;
    wr(5'd9, 32'h0000_0001);
    bus_b.write_en = 1'b0; bus_b.write_addr = 5'd9; bus_b.write_data = 32'hAAAA_AAAA;
    bus_b.read_addr1 = 5'd9; bus_b.read_addr2 = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sb.push_back({4{32'h0000_0001}});
      #1; exp_v = sb.pop_front(); n_vec++;
      if (w_obs !== exp_v) begin n_miss++; $display("FAIL write_disabled edge%0d got %h want %h", k, w_obs, exp_v); end
    end
  endtask

  task automatic test_sweep;
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) wr(5'(i), i * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      bus_b.read_addr1 = 5'(i);
      bus_b.read_addr2 = 5'(31 - i);
      e1 = i * 32'h0101_0101;
      e2 = (31 - i) * 32'h0101_0101;
      sb.push_back({e1, e2, e1, e2});
      #2; exp_v = sb.pop_front(); n_vec++;
      if (w_obs !== exp_v) begin n_miss++; $display("FAIL sweep pair %0d got %h want %h", i, w_obs, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_write_disable();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
